// File: rtl/tc77_responder_if.sv
// Three-wire TC77 serial bus (nCS / SCK / SIO) between the temperature loader
// (master) and the emulated sensor (slave); SIO is split into pad in/out/enable.
`timescale 1ns/1ps

interface tc77_responder_if;
  logic nCS;
  logic SCK;
  logic SIO_I;
  logic SIO_O;
  logic SIO_OE;

  modport master (
    output nCS,
    output SCK,
    output SIO_I,
    input  SIO_O,
    input  SIO_OE
  );

  modport slave (
    input  nCS,
    input  SCK,
    input  SIO_I,
    output SIO_O,
    output SIO_OE
  );
endinterface

// File: rtl/tc77_responder.sv
// TC77 temperature-sensor emulator: serialises {temp[12:0], conv, 2'b00} MSB first.
// Define TC77_CFG_WRITE_EN to accept the trailing 16-bit config word (shutdown control).
`timescale 1ns/1ps

module tc77_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_WORD     = 16'h5400
) (
  input  logic                 MCLK,
  input  logic                 nRESET,
  input  logic [12:0]          TEMP_IN,
  input  logic                 TEMP_VALID,
  tc77_responder_if.slave      spi,
  output logic                 SHUTDOWN,
  output logic                 FRAME_DONE
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] ncs_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] sio_sync_reg;
  logic                   ncs_prev_reg;
  logic                   sck_prev_reg;

  state_t      state_reg;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt_reg;
  logic [4:0]  bit_cnt_next;
  logic        sio_o_reg;
  logic        sio_oe_reg;
  logic        frame_done_reg;
  logic [12:0] hold_reg;
  logic        conv_reg;
  logic        shutdown_w;
  logic [15:0] frame_word;

  logic ncs_s, sck_s, sio_s;
  logic ncs_fall, ncs_rise, sck_rise, sck_fall;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      ncs_sync_reg <= '1;
      sck_sync_reg <= '0;
      sio_sync_reg <= '0;
      ncs_prev_reg <= 1'b1;
      sck_prev_reg <= 1'b0;
    end else begin
      ncs_sync_reg <= {ncs_sync_reg[SYNC_STAGES-2:0], spi.nCS};
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], spi.SCK};
      sio_sync_reg <= {sio_sync_reg[SYNC_STAGES-2:0], spi.SIO_I};
      ncs_prev_reg <= ncs_s;
      sck_prev_reg <= sck_s;
    end
  end

  assign ncs_s    = ncs_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign sio_s    = sio_sync_reg[SYNC_STAGES-1];
  assign ncs_fall = ncs_prev_reg & ~ncs_s;
  assign ncs_rise = ~ncs_prev_reg & ncs_s;
  // SCK activity only counts while the chip is selected
  assign sck_rise = ~sck_prev_reg & sck_s & ~ncs_s;
  assign sck_fall = sck_prev_reg & ~sck_s & ~ncs_s;

  assign bit_cnt_next = (bit_cnt_reg == 5'd31) ? 5'd31 : bit_cnt_reg + 5'd1;
  assign frame_word   = shutdown_w ? ID_WORD : {hold_reg, conv_reg, 2'b00};

  // A new sample always wins over the frame-start consume, so conv ends at 1 on a tie
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      hold_reg <= '0;
      conv_reg <= 1'b0;
    end else if (TEMP_VALID) begin
      hold_reg <= TEMP_IN;
      conv_reg <= 1'b1;
    end else if (state_reg == IDLE && ncs_fall) begin
      conv_reg <= 1'b0;
    end
  end

`ifdef TC77_CFG_WRITE_EN
  logic [15:0] cfg_reg;
  logic [3:0]  cfg_cnt_reg;
  logic        cfg_done_reg;
  logic        shutdown_reg;
  assign shutdown_w = shutdown_reg;
`else
  logic unused_sio;
  assign unused_sio = sio_s;
  assign shutdown_w = 1'b0;
`endif

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      sio_o_reg      <= 1'b0;
      sio_oe_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
`ifdef TC77_CFG_WRITE_EN
      cfg_reg        <= '0;
      cfg_cnt_reg    <= '0;
      cfg_done_reg   <= 1'b0;
      shutdown_reg   <= 1'b0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
      if (state_reg != IDLE && ncs_rise) begin
        state_reg      <= IDLE;
        sio_oe_reg     <= 1'b0;
        frame_done_reg <= (bit_cnt_reg >= 5'd16);
`ifdef TC77_CFG_WRITE_EN
        if (cfg_done_reg) begin
          if (cfg_reg == 16'hFFFF)
            shutdown_reg <= 1'b1;
          else if (cfg_reg == 16'h0000)
            shutdown_reg <= 1'b0;
        end
        cfg_done_reg <= 1'b0;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (ncs_fall) begin
              shift_reg   <= frame_word;
              sio_o_reg   <= frame_word[15];
              sio_oe_reg  <= 1'b1;
              bit_cnt_reg <= '0;
`ifdef TC77_CFG_WRITE_EN
              cfg_cnt_reg  <= '0;
              cfg_done_reg <= 1'b0;
`endif
              state_reg   <= READ;
            end
          end
          READ: begin
            if (sck_rise) begin
              bit_cnt_reg <= bit_cnt_next;
              // bits 1:0 are left floating, as on the real part
              if (bit_cnt_next >= 5'd14)
                sio_oe_reg <= 1'b0;
              if (bit_cnt_next >= 5'd16) begin
`ifdef TC77_CFG_WRITE_EN
                state_reg <= WRITE;
`else
                state_reg <= WAIT_CS;
`endif
              end
            end else if (sck_fall) begin
              shift_reg <= {shift_reg[14:0], 1'b0};
              sio_o_reg <= shift_reg[14];
            end
          end
          WRITE: begin
            sio_oe_reg <= 1'b0;
`ifdef TC77_CFG_WRITE_EN
            if (sck_rise) begin
              cfg_reg     <= {cfg_reg[14:0], sio_s};
              cfg_cnt_reg <= cfg_cnt_reg + 4'd1;
              if (cfg_cnt_reg == 4'd15) begin
                cfg_done_reg <= 1'b1;
                state_reg    <= WAIT_CS;
              end
            end
`else
            state_reg <= WAIT_CS;
`endif
          end
          WAIT_CS: sio_oe_reg <= 1'b0;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign spi.SIO_O  = sio_o_reg;
  assign spi.SIO_OE = sio_oe_reg;
  assign FRAME_DONE = frame_done_reg;
  assign SHUTDOWN   = shutdown_w;

endmodule

// File: tb/tb_tc77_responder.sv
// Bench for tc77_responder: bus initiator plus a word-level sensor model
// (holding value, conv flag, shutdown) that predicts every frame.
`timescale 1ns/1ps

module tb_tc77_responder;
  localparam int          SYNC = 2;
  localparam logic [15:0] IDW  = 16'h5400;

  logic        MCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [12:0] TEMP_IN = '0;
  logic        TEMP_VALID = 1'b0;
  logic        SHUTDOWN;
  logic        FRAME_DONE;

  tc77_responder_if bus();

  tc77_responder #(.SYNC_STAGES(SYNC), .ID_WORD(IDW)) dut (
    .MCLK       (MCLK),
    .nRESET     (nRESET),
    .TEMP_IN    (TEMP_IN),
    .TEMP_VALID (TEMP_VALID),
    .spi        (bus),
    .SHUTDOWN   (SHUTDOWN),
    .FRAME_DONE (FRAME_DONE)
  );

  always #10 MCLK = ~MCLK;

  int          total = 0;
  int          bad = 0;
  int          fd_count = 0;
  bit          settled = 1'b0;
  logic [12:0] hold_m = '0;
  bit          conv_m = 1'b0;
  bit          shdn_m = 1'b0;
  logic [15:0] got;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word();
    return shdn_m ? IDW : {hold_m, conv_m, 2'b00};
  endfunction

  always @(posedge MCLK) if (FRAME_DONE === 1'b1) fd_count <= fd_count + 1;

  // Between frames the pad must be released, no pulse may appear, and SHUTDOWN must match the model
  always @(negedge MCLK) begin
    if (settled && nRESET) begin
      check("idle_oe", 16'(bus.SIO_OE), 16'h0);
      check("idle_fd", 16'(FRAME_DONE), 16'h0);
      check("idle_shdn", 16'(SHUTDOWN), 16'(shdn_m));
    end
  end

  // Caller is at posedge+1
  task automatic pulse_load(input logic [12:0] v);
    TEMP_IN    = v;
    TEMP_VALID = 1'b1;
    @(posedge MCLK); #1;
    TEMP_VALID = 1'b0;
    hold_m = v;
    conv_m = 1'b1;
  endtask

  // load_at: SCK high phase in which TEMP_VALID pulses (-1 = aligned with frame start)
  // rst_at : clock index at which nRESET is pulsed (out of range = never)
  task automatic run_frame(input int nclk, input logic [15:0] wdata, input int load_at,
                           input logic [12:0] load_val, input int rst_at,
                           output logic [15:0] word_got);
    logic [15:0] exp, oe_got, mask;
    int fd0, n;
    settled = 1'b0;
    word_got = '0;
    oe_got = '0;
    fd0 = fd_count;
    @(posedge MCLK); #1;
    bus.nCS = 1'b0;
    exp = model_word();
    conv_m = 1'b0;
    if (load_at < 0) begin
      repeat (SYNC) @(posedge MCLK);
      #1;
      pulse_load(load_val);
      repeat (5) @(posedge MCLK);
    end else begin
      repeat (8) @(posedge MCLK);
    end
    #1;
    for (int i = 0; i < nclk; i++) begin
      if (i == rst_at) begin
        nRESET = 1'b0;
        #1;
        check("rst_oe", 16'(bus.SIO_OE), 16'h0);
        check("rst_o", 16'(bus.SIO_O), 16'h0);
        check("rst_shdn", 16'(SHUTDOWN), 16'h0);
        check("rst_fd", 16'(FRAME_DONE), 16'h0);
        bus.nCS = 1'b1;
        hold_m = '0; conv_m = 1'b0; shdn_m = 1'b0;
        repeat (3) @(posedge MCLK);
        #1 nRESET = 1'b1;
        repeat (4) @(posedge MCLK);
        #1;
        check("rst_nofd", 16'(fd_count - fd0), 16'h0);
        settled = 1'b1;
        return;
      end
      if (i < 16) begin
        word_got[15-i] = bus.SIO_O;
        oe_got[15-i]   = bus.SIO_OE;
      end else begin
        check("wr_oe", 16'(bus.SIO_OE), 16'h0);
      end
      bus.SCK = 1'b1;
      if (i == load_at) begin
        pulse_load(load_val);
        repeat (3) @(posedge MCLK);
      end else begin
        repeat (4) @(posedge MCLK);
      end
      #1;
      bus.SCK = 1'b0;
      if (i + 1 >= 16 && i + 1 < 32) bus.SIO_I = wdata[31-(i+1)];
      repeat (4) @(posedge MCLK);
      #1;
    end
    n = (nclk > 16) ? 16 : nclk;
    mask = ~(16'hFFFF >> n);
    check("word", word_got & mask & 16'hFFFC, exp & mask & 16'hFFFC);
    check("oe_pattern", oe_got & mask, 16'hFFFC & mask);
    bus.nCS = 1'b1;
    bus.SIO_I = 1'b0;
    repeat (SYNC + 2) @(posedge MCLK);
    #1;
    check("cs_oe", 16'(bus.SIO_OE), 16'h0);
    repeat (6) @(posedge MCLK);
    #1;
    check("frame_done", 16'(fd_count - fd0), (nclk >= 16) ? 16'h1 : 16'h0);
`ifdef TC77_CFG_WRITE_EN
    if (nclk >= 32) begin
      if (wdata == 16'hFFFF) shdn_m = 1'b1;
      else if (wdata == 16'h0000) shdn_m = 1'b0;
    end
`endif
    check("shdn_after", 16'(SHUTDOWN), 16'(shdn_m));
    $display("frame nclk=%0d got=%h exp=%h shdn=%0b", nclk, word_got, exp, SHUTDOWN);
    settled = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nclk, sel, load_at;
    logic [15:0] wd;
    bus.nCS = 1'b1;
    bus.SCK = 1'b0;
    bus.SIO_I = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    check("reset_sio_o", 16'(bus.SIO_O), 16'h0);
    check("reset_sio_oe", 16'(bus.SIO_OE), 16'h0);
    check("reset_shdn", 16'(SHUTDOWN), 16'h0);
    check("reset_fd", 16'(FRAME_DONE), 16'h0);
    nRESET = 1'b1;
    repeat (3) @(posedge MCLK);
    #1;
    settled = 1'b1;

    pulse_load(13'h0190);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_25c", got & 16'hFFFC, 16'h0C84);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_noconv", got & 16'hFFFC, 16'h0C80);

    run_frame(16, 16'h0, 5, 13'h1F38, 99, got);
    check("lit_midload_old", got & 16'hFFFC, 16'h0C80);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_neg12p5", got & 16'hFFFC, 16'hF9C4);

    run_frame(7, 16'h0, 99, '0, 99, got);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_after_abort", got & 16'hFFFC, 16'hF9C0);

    run_frame(16, 16'h0, -1, 13'h0ABC, 99, got);
    check("lit_tie_old", got & 16'hFFFC, 16'hF9C0);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_tie_new", got & 16'hFFFC, 16'h55E4);

`ifdef TC77_CFG_WRITE_EN
    run_frame(32, 16'hFFFF, 99, '0, 99, got);
    check("lit_shdn_set", 16'(SHUTDOWN), 16'h1);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_id_word", got & 16'hFFFC, 16'h5400);
    run_frame(32, 16'h1234, 99, '0, 99, got);
    check("lit_shdn_keep1", 16'(SHUTDOWN), 16'h1);
    run_frame(32, 16'h0000, 99, '0, 99, got);
    check("lit_shdn_clr", 16'(SHUTDOWN), 16'h0);
    run_frame(32, 16'h1234, 99, '0, 99, got);
    check("lit_shdn_keep0", 16'(SHUTDOWN), 16'h0);
`endif

    run_frame(16, 16'h0, 99, '0, 9, got);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_post_reset", got & 16'hFFFC, 16'h0000);
    pulse_load(13'h0FFF);
    run_frame(16, 16'h0, 99, '0, 99, got);
    check("lit_max_pos", got & 16'hFFFC, 16'h7FFC);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) pulse_load(13'($urandom));
      sel = $urandom_range(0, 9);
      if (sel < 2)      nclk = $urandom_range(1, 15);
      else if (sel < 5) nclk = 32;
      else              nclk = $urandom_range(16, 20);
      case ($urandom_range(0, 2))
        0:       wd = 16'hFFFF;
        1:       wd = 16'h0000;
        default: wd = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0)      load_at = $urandom_range(0, nclk - 1);
      else if ($urandom_range(0, 5) == 0) load_at = -1;
      else                                load_at = 99;
      run_frame(nclk, wd, load_at, 13'($urandom), 99, got);
    end

    repeat (4) @(posedge MCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc77_responder.md
Name: tc77_responder

Overview:
- Emulates the TC77 SPI temperature sensor as a bus target on the nCS/SCK/SIO three-wire interface.
- Our temperature loader is the initiator on that interface. This block lets it be exercised in-system and on the bench without a physical TC77, driven from a digital temperature source.
- Serialises a 13-bit temperature plus a conversion-complete flag, MSB first.
- Optionally accepts the 16-bit configuration write that follows the read word: shutdown / continuous mode.

Parameters:
- SYNC_STAGES, 2, number of MCLK flip-flop stages synchronising nCS, SCK and SIO_I (allowed values 2..3).
- ID_WORD, 16'h5400, word returned in place of the temperature while in shutdown.

Ports:
- MCLK  in  1  system clock, 48 MHz nominal; the only clock.
- nRESET  in  1  reset, asynchronous assert, active-low.
- TEMP_IN  in  13  two's-complement temperature, 0.0625 °C/LSB.
- TEMP_VALID  in  1  one-MCLK strobe; loads TEMP_IN into the holding register.
- nCS  in  1  chip select from the initiator, active-low; asynchronous to MCLK.
- SCK  in  1  serial clock from the initiator, idle low; asynchronous to MCLK.
- SIO_I  in  1  SIO pad input (config write data).
- SIO_O  out  1  SIO pad output data.
- SIO_OE  out  1  SIO pad output enable; 1 = drive.
- SHUTDOWN  out  1  1 = emulated device is in shutdown mode.
- FRAME_DONE  out  1  one-MCLK pulse on nCS rise after a read of at least 16 bits.

Behaviour:
- Reset (nRESET=0) values:
  - SIO_O=0, SIO_OE=0, SHUTDOWN=0, FRAME_DONE=0.
  - Holding register=0, conv flag=0, bit counter=0, state=IDLE.
  - Synchroniser stages preset to nCS=1, SCK=0.
- Input synchronisation and edges:
  - nCS, SCK and SIO_I pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised copies.
  - Initiator SCK high and low phases are at least 4 MCLK each.
- Holding register and conv flag:
  - TEMP_VALID writes TEMP_IN into the holding register and sets conv=1.
  - Holding register updates are never blocked, including mid-frame.
- State machine: IDLE, READ, WRITE, WAIT_CS.
- IDLE:
  - On the synchronised nCS fall, load shift[15:0] = SHUTDOWN ? ID_WORD : {hold[12:0], conv, 2'b00}.
  - Clear conv and the bit counter, then go to READ.
  - In the same cycle assert SIO_OE=1 and SIO_O=shift[15].
  - Latency: pad nCS fall to SIO valid is ≤ SYNC_STAGES+2 MCLK.
- READ:
  - On each synchronised SCK rise, increment the bit counter.
  - On each SCK fall, shift left and present the next bit; SIO_O is stable across each SCK rise.
  - Bits 1:0 are not driven: SIO_OE=0 once the bit counter reaches 14.
  - When the counter reaches 16: go to WRITE if TC77_CFG_WRITE_EN is compiled in, else go to WAIT_CS.
- WRITE:
  - SIO_OE=0.
  - On each SCK rise, capture SIO_I into cfg[15:0], MSB first.
  - After 16 captures, go to WAIT_CS and mark cfg complete.
- WAIT_CS: SIO_OE=0; further SCK edges are ignored.
- nCS rise (synchronised), in any non-IDLE state:
  - Set SIO_OE=0 and return to IDLE.
  - Pulse FRAME_DONE if at least 16 read bits were clocked.
  - If cfg is complete: cfg==16'hFFFF sets SHUTDOWN=1; cfg==16'h0000 clears SHUTDOWN; any other value leaves SHUTDOWN unchanged.
- Aborted frame (nCS rises before 16 bits):
  - No FRAME_DONE, no config change.
  - conv stays cleared, because it was consumed at frame start.
- Bit counter width is 5 bits and saturates at 31; it never wraps within a frame.
- SCK edges while nCS is high are ignored.
- Simultaneous TEMP_VALID and nCS fall in the same cycle:
  - The frame snapshots the old holding value.
  - The new value is stored and conv ends at 1.
- nRESET assertion mid-frame:
  - Immediately sets SIO_OE=0 and returns to IDLE.
  - A frame already in progress is not resumed; the next nCS fall starts a fresh frame.

Optional Feature:
- Macro: TC77_CFG_WRITE_EN.
- Defined: the WRITE state, cfg capture and SHUTDOWN control are present. In shutdown the read word is ID_WORD.
- Undefined:
  - READ goes directly to WAIT_CS after 16 bits; SIO_I is ignored.
  - SHUTDOWN is tied 0, so ID_WORD is never output.

Test Plan:
- Reset, then TEMP_VALID with TEMP_IN=13'h0190 (+25 °C); 16-clock read at 6 MHz SCK → bits sampled on SCK rise are 0x0C84 for bits 15:2; SIO_OE=0 for the last two bits; FRAME_DONE pulses once.
- Second read with no new TEMP_VALID → bit 2 = 0; temperature bits unchanged (0x190).
- TEMP_IN=13'h1F38 (−12.5 °C) loaded mid-frame → current frame still returns the old value; next frame returns 0x1F38 with conv=1.
- nCS raised after 7 clocks → SIO_OE=0 within SYNC_STAGES+2 MCLK; no FRAME_DONE; next full frame is correct.
- TC77_CFG_WRITE_EN defined, 32-clock frame writing 0xFFFF → SHUTDOWN=1 after nCS rise; next read returns 0x5400. Then a 0x0000 write → SHUTDOWN=0. Then a 0x1234 write → no change.
- nRESET pulsed at bit 9 of a read → SIO_OE=0 immediately; all outputs hold reset values; the next frame starts cleanly from bit 15.
